// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if : decode-side and execute-side handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic [31:0]      instr_in;
  logic [2:0]       imm_src_in;
  logic [TAG_W-1:0] tag_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [XLEN-1:0]  ext_imm_out;
  logic [TAG_W-1:0] tag_out;
  logic             illegal_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output instr_in, imm_src_in, tag_in, in_valid, flush, out_ready,
    input  in_ready, ext_imm_out, tag_out, illegal_out, out_valid
  );

  modport slave (
    input  instr_in, imm_src_in, tag_in, in_valid, flush, out_ready,
    output in_ready, ext_imm_out, tag_out, illegal_out, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe : registered immediate generator behind a two-entry skid buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input wire           clk,
  input wire           rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_one   = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic             w_main_sel_skid;
  logic             w_skid_ld;

  logic [63:0]      w_imm64;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_s;
  logic [31:0]      w_i;

  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;
  logic             w_unused_ok;

  assign w_i         = bus.instr_in;
  assign w_s         = w_i[31];
  assign w_unused_ok = ^w_i[6:0];

  // Decode at full 64-bit width, then keep the low XLEN bits.
  always_comb begin
    w_imm64 = '0;
    case (bus.imm_src_in)
      3'b001:  w_imm64 = {{52{w_s}}, w_i[31:25], w_i[11:7]};
      3'b010:  w_imm64 = {{51{w_s}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      3'b011:  w_imm64 = {{43{w_s}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      3'b100:  w_imm64 = {{32{w_s}}, w_i[31:12], 12'b0};
      3'b101:  w_imm64 = (XLEN == 64) ? {58'b0, w_i[25:20]} : {59'b0, w_i[24:20]};
      3'b110:  w_imm64 = {59'b0, w_i[19:15]};
      default: w_imm64 = {{52{w_s}}, w_i[31:20]};
    endcase
  end

  assign w_imm = w_imm64[XLEN-1:0];
  assign w_ill = (bus.imm_src_in == 3'b111);

  assign w_out_valid = (r_state != c_st_empty);
  assign w_in_ready  = (r_state != c_st_full);
  assign w_in_fire   = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_empty;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = c_st_empty;
    end else begin
      case (r_state)
        c_st_empty: if (w_in_fire) w_next = c_st_one;
        c_st_one: begin
          if (w_in_fire && !w_out_fire)      w_next = c_st_full;
          else if (!w_in_fire && w_out_fire) w_next = c_st_empty;
        end
        c_st_full:  if (w_out_fire) w_next = c_st_one;
        default:    w_next = c_st_empty;
      endcase
    end
  end

  // Load strobes; an input beat is never taken in a flush cycle.
  always_comb begin
    w_main_ld       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_ld       = 1'b0;
    case (r_state)
      c_st_empty: w_main_ld = w_in_fire;
      c_st_one: begin
        w_main_ld = w_in_fire & w_out_fire;
        w_skid_ld = w_in_fire & ~w_out_fire;
      end
      c_st_full: begin
        w_main_ld       = w_out_fire & ~bus.flush;
        w_main_sel_skid = 1'b1;
      end
      default: w_main_ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_ill <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_main_ld) begin
        if (w_main_sel_skid) begin
          r_main_imm <= r_skid_imm;
          r_main_tag <= r_skid_tag;
          r_main_ill <= r_skid_ill;
        end else begin
          r_main_imm <= w_imm;
          r_main_tag <= bus.tag_in;
          r_main_ill <= w_ill;
        end
      end
      if (w_skid_ld) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= bus.tag_in;
        r_skid_ill <= w_ill;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.ext_imm_out = r_main_imm;
  assign bus.tag_out     = r_main_tag;
  assign bus.illegal_out = r_main_ill;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe : bench for imm_gen_pipe at XLEN 32 and 64
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imm_gen_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  int checks   = 0;
  int errors   = 0;
  int accepted = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  ent_t q[$];

  // Immediate value computed arithmetically from the field definitions.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint v;
    longint sgn;
    sgn = longint'(ins[31]);
    case (src)
      3'd1:    v = {ins[31:25], ins[11:7]} - sgn * 4096;
      3'd2:    v = {ins[31], ins[7], ins[30:25], ins[11:8]} * 2 - sgn * 8192;
      3'd3:    v = {ins[31], ins[19:12], ins[20], ins[30:21]} * 2 - sgn * (longint'(1) << 21);
      3'd4:    v = ins[31:12] * 4096 - sgn * (longint'(1) << 32);
      3'd5:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6:    v = longint'(ins[19:15]);
      default: v = ins[31:20] - sgn * 4096;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // One clock of the 32-bit instance, checked against the queue model.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] src,
                     input logic [4:0] tg, input logic ordy, input logic fl);
    logic exp_rdy, exp_vld, inf, outf;
    ent_t e;
    b32.in_valid   = v;
    b32.instr_in   = ins;
    b32.imm_src_in = src;
    b32.tag_in     = tg;
    b32.out_ready  = ordy;
    b32.flush      = fl;
    #1;
    exp_rdy = (q.size() < 2);
    exp_vld = (q.size() > 0);
    checks++;
    if (b32.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", b32.in_ready, exp_rdy, $time);
    end
    checks++;
    if (b32.out_valid !== exp_vld) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", b32.out_valid, exp_vld, $time);
    end
    if (exp_vld) begin
      checks++;
      if ({b32.ext_imm_out, b32.tag_out, b32.illegal_out} !== {q[0].imm[31:0], q[0].tag, q[0].ill}) begin
        errors++;
        $display("FAIL head: got imm %h tag %0d ill %b expected imm %h tag %0d ill %b at %0t",
                 b32.ext_imm_out, b32.tag_out, b32.illegal_out,
                 q[0].imm[31:0], q[0].tag, q[0].ill, $time);
      end
    end
    inf  = v && exp_rdy && !fl;
    outf = exp_vld && ordy;
    if (inf) accepted++;
    @(posedge clk);
    if (outf) void'(q.pop_front());
    if (fl) q.delete();
    else if (inf) begin
      e.imm = ref_imm(ins, src, 32);
      e.tag = tg;
      e.ill = (src == 3'b111);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    b32.in_valid = 0; b32.instr_in = '0; b32.imm_src_in = '0; b32.tag_in = '0;
    b32.out_ready = 0; b32.flush = 0;
    b64.in_valid = 0; b64.instr_in = '0; b64.imm_src_in = '0; b64.tag_in = '0;
    b64.out_ready = 1; b64.flush = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.ext_imm_out, b32.tag_out, b32.illegal_out} !== {2'b01, 38'b0}) begin
      errors++;
      $display("FAIL reset32: got vld %b rdy %b imm %h tag %0d ill %b", b32.out_valid,
               b32.in_ready, b32.ext_imm_out, b32.tag_out, b32.illegal_out);
    end
    checks++;
    if ({b64.out_valid, b64.in_ready, b64.ext_imm_out} !== {2'b01, 64'b0}) begin
      errors++;
      $display("FAIL reset64: got vld %b rdy %b imm %h", b64.out_valid, b64.in_ready, b64.ext_imm_out);
    end
    rst_n = 1'b1;
    // Fill to FULL, then reset asynchronously between edges.
    cyc(1, 32'hFFF0_0093, 3'd0, 5'd1, 0, 0);
    cyc(1, 32'h0040_0093, 3'd0, 5'd2, 0, 0);
    cyc(0, 32'h0, 3'd0, 5'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.ext_imm_out, b32.tag_out} !== {2'b01, 37'b0}) begin
      errors++;
      $display("FAIL reset_mid: got vld %b rdy %b imm %h tag %0d", b32.out_valid, b32.in_ready,
               b32.ext_imm_out, b32.tag_out);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h0070_0093, 3'd0, 5'd9, 1, 0);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.tag_out !== 5'd9 || b32.ext_imm_out !== 32'h7) begin
      errors++;
      $display("FAIL reset_release: got vld %b tag %0d imm %h expected 1 9 00000007",
               b32.out_valid, b32.tag_out, b32.ext_imm_out);
    end
    cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
  endtask

  task automatic test_formats();
    logic [31:0] fi [5];
    logic [2:0]  fs [5];
    logic [31:0] fe [5];
    fi = '{32'hFFF0_0093, 32'h8000_00EF, 32'h00C0_006F, 32'h4051_5093, 32'h000F_D073};
    fs = '{3'd0, 3'd3, 3'd3, 3'd5, 3'd6};
    fe = '{32'hFFFF_FFFF, 32'hFFF0_0000, 32'h0000_000C, 32'h0000_0005, 32'h0000_001F};
    for (int i = 0; i < 5; i++) begin
      cyc(1, fi[i], fs[i], 5'(i + 10), 1, 0);
      checks++;
      if (b32.out_valid !== 1'b1 || b32.ext_imm_out !== fe[i]) begin
        errors++;
        $display("FAIL format%0d: got vld %b imm %h expected 1 %h", i, b32.out_valid,
                 b32.ext_imm_out, fe[i]);
      end
    end
    cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
  endtask

  task automatic test_xlen64();
    logic [31:0] xi [3];
    logic [2:0]  xs [3];
    logic [63:0] xe [3];
    logic        xl [3];
    xi = '{32'h8000_02B7, 32'h03F0_1013, 32'hFFF0_0093};
    xs = '{3'd4, 3'd5, 3'd7};
    xe = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_003F, 64'hFFFF_FFFF_FFFF_FFFF};
    xl = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      b64.in_valid = 1; b64.instr_in = xi[i]; b64.imm_src_in = xs[i]; b64.tag_in = 5'(i);
      @(posedge clk);
      @(negedge clk);
      b64.in_valid = 0;
      #1;
      checks++;
      if (b64.out_valid !== 1'b1 || b64.ext_imm_out !== xe[i] || b64.illegal_out !== xl[i]) begin
        errors++;
        $display("FAIL xlen64_%0d: got vld %b imm %h ill %b expected 1 %h %b", i,
                 b64.out_valid, b64.ext_imm_out, b64.illegal_out, xe[i], xl[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 32'h0010_0093, 3'd0, 5'd1, 0, 0);
    cyc(1, 32'h0020_0093, 3'd0, 5'd2, 0, 0);
    cyc(1, 32'h0030_0093, 3'd0, 5'd3, 0, 0);
    checks++;
    if (b32.in_ready !== 1'b0 || b32.tag_out !== 5'd1) begin
      errors++;
      $display("FAIL bp_full: got rdy %b tag %0d expected 0 1", b32.in_ready, b32.tag_out);
    end
    cyc(1, 32'h0030_0093, 3'd0, 5'd3, 1, 0);
    checks++;
    if (b32.tag_out !== 5'd2) begin
      errors++;
      $display("FAIL bp_order2: got tag %0d expected 2", b32.tag_out);
    end
    cyc(1, 32'h0030_0093, 3'd0, 5'd3, 1, 0);
    checks++;
    if (b32.tag_out !== 5'd3 || b32.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_order3: got tag %0d vld %b expected 3 1", b32.tag_out, b32.out_valid);
    end
    cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got vld %b expected 0", b32.out_valid);
    end
  endtask

  task automatic test_flush();
    cyc(1, 32'h0010_0093, 3'd0, 5'd4, 0, 0);
    cyc(1, 32'h0020_0093, 3'd0, 5'd5, 0, 0);
    cyc(1, 32'h0050_0093, 3'd0, 5'd7, 0, 1);
    checks++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: got vld %b rdy %b expected 0 1", b32.out_valid, b32.in_ready);
    end
    cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_beat: got vld %b tag %0d expected no entry", b32.out_valid, b32.tag_out);
    end
  endtask

  task automatic test_random();
    int ncyc = 0;
    while (accepted < 10000 && ncyc < 40000) begin
      cyc(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
      ncyc++;
    end
    checks++;
    if (accepted < 10000) begin
      errors++;
      $display("FAIL random_budget: got %0d beats expected 10000", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
